// File: rtl/debug_ctrl.sv
// Debug controller: decodes UART command bytes to run, single-step or halt
// a datapath, and dumps a snapshot of the datapath state bus as a framed,
// XOR-checksummed byte stream through a UART transmitter.
module debug_ctrl #(
  parameter int         BUS_W    = 1401,
  parameter logic [7:0] HDR      = 8'hA5,
  parameter logic [7:0] CMD_RUN  = 8'h63,
  parameter logic [7:0] CMD_STEP = 8'h73,
  parameter logic [7:0] CMD_DUMP = 8'h64,
  parameter logic [7:0] CMD_STOP = 8'h70
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_rdy,
  input  logic [7:0]       rx_data,
  input  logic             tx_busy,
  input  logic [BUS_W-1:0] dp_bus,
  input  logic             halt_in,
  output logic             dp_clk_en,
  output logic             tx_write,
  output logic [7:0]       tx_data,
  output logic             busy
);

  // Number of whole bytes needed to carry the bus; the last byte is padded
  // with zeros when BUS_W is not a multiple of eight.
  localparam int NBYTES = (BUS_W + 7) / 8;
  localparam int SH_W   = NBYTES * 8;
  localparam int CNT_W  = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_SNAP,
    S_SEND,
    S_WAIT
  } state_t;

  state_t state;
  state_t state_next;

  // Snapshot of the bus; shifted right one byte per data byte sent so the
  // next byte to transmit is always in the low eight bits.
  logic [SH_W-1:0]  shadow;
  logic [SH_W-1:0]  bus_ext;
  logic [CNT_W-1:0] byte_idx;
  logic [7:0]       csum;
  logic             hdr_sent;
  logic             csum_sent;
  logic [7:0]       cur_byte;
  logic             do_write;
  logic             en_next;

  assign busy = (state != S_IDLE);

  // Zero-extend the live bus to a whole number of bytes.
  always_comb begin
    bus_ext              = '0;
    bus_ext[BUS_W-1:0]   = dp_bus;
  end

  // Select the frame byte due next: header, then data bytes, then checksum.
  always_comb begin
    if (!hdr_sent) begin
      cur_byte = HDR;
    end else if (byte_idx != LAST_IDX) begin
      cur_byte = shadow[7:0];
    end else begin
      cur_byte = csum;
    end
  end

  // Next-state decode plus the strobes that drive the registered outputs.
  always_comb begin
    state_next = state;
    do_write   = 1'b0;
    en_next    = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_rdy) begin
          if (rx_data == CMD_RUN) begin
            state_next = S_RUN;
          end else if (rx_data == CMD_STEP) begin
            state_next = S_STEP;
          end else if (rx_data == CMD_DUMP) begin
            state_next = S_SNAP;
          end
        end
      end
      S_RUN: begin
        en_next = 1'b1;
        if (halt_in) begin
          state_next = S_SNAP;
        end else if (rx_rdy && (rx_data == CMD_STOP)) begin
          state_next = S_IDLE;
        end
      end
      S_STEP: begin
        en_next    = !halt_in;
        state_next = S_SNAP;
      end
      S_SNAP: begin
        state_next = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy) begin
          do_write   = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        state_next = csum_sent ? S_IDLE : S_SEND;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register; reset returns to IDLE without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered outputs and frame bookkeeping (snapshot, pointer, checksum).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_clk_en <= 1'b0;
      tx_write  <= 1'b0;
      tx_data   <= 8'h00;
      shadow    <= '0;
      byte_idx  <= '0;
      csum      <= 8'h00;
      hdr_sent  <= 1'b0;
      csum_sent <= 1'b0;
    end else begin
      dp_clk_en <= en_next;
      tx_write  <= do_write;
      if (do_write) begin
        tx_data <= cur_byte;
      end
      if (state == S_SNAP) begin
        shadow    <= bus_ext;
        byte_idx  <= '0;
        csum      <= 8'h00;
        hdr_sent  <= 1'b0;
        csum_sent <= 1'b0;
      end else if (do_write) begin
        if (!hdr_sent) begin
          hdr_sent <= 1'b1;
        end else if (byte_idx != LAST_IDX) begin
          shadow   <= shadow >> 8;
          csum     <= csum ^ shadow[7:0];
          byte_idx <= byte_idx + 1'b1;
        end else begin
          csum_sent <= 1'b1;
        end
      end
    end
  end

endmodule
